// File: rtl/cv32e40p_x_pkg.sv
// Shared types and constants for the X-interface offload controller.
package cv32e40p_x_pkg;

    localparam int X_NUM_RS_MAX = 3;
    localparam int REGADDR_W    = 5;
    localparam int XLEN         = 32;
    localparam int CNT_W        = 4;

    typedef logic [31:0] sb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        REJECT = 2'd2
    } x_state_e;

    // One-hot register mask; x0 is never tracked, so it maps to an empty mask.
    function automatic sb_t reg_mask(input logic [REGADDR_W-1:0] addr);
        sb_t m;
        m = '0;
        if (addr != '0) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cv32e40p_x_scoreboard.sv
// Destination-register scoreboard and outstanding-offload counter.
module cv32e40p_x_scoreboard
    import cv32e40p_x_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_i,
    input  logic [REGADDR_W-1:0] set_addr_i,
    input  logic                 set_pair_i,
    input  logic                 clr_i,
    input  logic [REGADDR_W-1:0] clr_addr_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output sb_t                  sb_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    sb_t              sb_q;
    sb_t              set_mask;
    sb_t              clr_mask;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) begin
            set_mask = reg_mask(set_addr_i);
            if (set_pair_i) begin
                set_mask = set_mask | reg_mask(set_addr_i | 5'd1);
            end
        end
        if (clr_i) begin
            clr_mask = reg_mask(clr_addr_i);
        end
    end

    // Set is applied after clear so a same-cycle set on the same register wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_q    <= '0;
            count_q <= '0;
        end else begin
            sb_q <= (sb_q & ~clr_mask) | set_mask;
            if (inc_i && !dec_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (dec_i && !inc_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign sb_o    = sb_q;
    assign count_o = count_q;
    assign full_o  = (count_q >= MAX_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cv32e40p_x_offload_ctrl.sv
// Offload sequencer between ID and the X-interface: request handshake, hazard stall, result writeback.
// Optional dual-writeback results are enabled with `define CV32E40P_X_DUALWB_EN.
//
// state  | meaning
// IDLE   | no request in flight; ID may present an offload
// ISSUE  | x_valid_o held with registered payload until x_ready_i
// REJECT | coprocessor declined; one-cycle illegal-instruction pulse
module cv32e40p_x_offload_ctrl
    import cv32e40p_x_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int X_NUM_RS        = 3
)(
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    id_offload_valid_i,
    input  logic [XLEN-1:0]                         id_instr_i,
    input  logic [X_NUM_RS_MAX-1:0][XLEN-1:0]       id_rs_i,
    input  logic [X_NUM_RS_MAX-1:0][REGADDR_W-1:0]  id_rs_addr_i,
    input  logic [REGADDR_W-1:0]                    id_rd_addr_i,
    output logic                                    id_stall_o,
    output logic                                    id_offload_done_o,
    output logic                                    id_illegal_o,
    output logic                                    x_valid_o,
    input  logic                                    x_ready_i,
    output logic [XLEN-1:0]                         x_instr_data_o,
    output logic [X_NUM_RS_MAX-1:0][XLEN-1:0]       x_rs_o,
    output logic [X_NUM_RS_MAX-1:0]                 x_rs_valid_o,
    output logic                                    x_rd_clean_o,
    input  logic                                    x_accept_i,
    input  logic                                    x_writeback_i,
    input  logic                                    x_rvalid_i,
    output logic                                    x_rready_o,
    input  logic [REGADDR_W-1:0]                    x_rd_i,
    input  logic [XLEN-1:0]                         x_data_i,
    input  logic                                    x_dualwb_i,
    input  logic                                    x_error_i,
    input  logic                                    core_wb_we_i,
    output logic                                    rf_x_we_o,
    output logic [REGADDR_W-1:0]                    rf_x_waddr_o,
    output logic [XLEN-1:0]                         rf_x_wdata_o,
    output logic                                    x_err_o,
    output logic [CNT_W-1:0]                        outstanding_o
);

    localparam logic [X_NUM_RS_MAX-1:0] RS_VALID = (X_NUM_RS == 2) ? 3'b011 : 3'b111;

    x_state_e                          state_q;
    x_state_e                          state_d;
    logic [XLEN-1:0]                   instr_q;
    logic [X_NUM_RS_MAX-1:0][XLEN-1:0] rs_q;
    logic [REGADDR_W-1:0]              rd_q;
    logic                              rd_clean_q;
    logic                              rd_pair;
    logic                              rd_pair_q;

    sb_t                               sb;
    logic [CNT_W-1:0]                  count;
    logic                              full;
    logic                              empty;

    logic                              rs_hazard;
    logic                              rd_hazard;
    logic                              hazard;
    logic                              issue;
    logic                              sb_set;
    logic                              res_hs;
    logic                              res_fire;
    logic                              dual_first;
    logic [REGADDR_W-1:0]              wb_addr;

    always_comb begin
        rs_hazard = 1'b0;
        for (int i = 0; i < X_NUM_RS_MAX; i++) begin
            if (RS_VALID[i] && sb[id_rs_addr_i[i]]) begin
                rs_hazard = 1'b1;
            end
        end
    end

`ifdef CV32E40P_X_DUALWB_EN
    assign rd_pair = ~id_rd_addr_i[0];
`else
    assign rd_pair = 1'b0;
`endif

    assign rd_hazard  = sb[id_rd_addr_i] | (rd_pair & sb[id_rd_addr_i | 5'd1]);
    assign hazard     = rs_hazard | rd_hazard | full;
    assign id_stall_o = id_offload_valid_i && ((state_q != IDLE) || hazard);
    assign issue      = (state_q == IDLE) && id_offload_valid_i && !hazard;

    always_comb begin
        state_d           = state_q;
        id_offload_done_o = 1'b0;
        id_illegal_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (x_ready_i) begin
                    if (x_accept_i) begin
                        id_offload_done_o = 1'b1;
                        state_d           = IDLE;
                    end else begin
                        state_d = REJECT;
                    end
                end
            end
            REJECT: begin
                id_illegal_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload is captured at issue so it stays stable however long ID or the coprocessor stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            rs_q       <= '0;
            rd_q       <= '0;
            rd_clean_q <= 1'b0;
            rd_pair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                instr_q    <= id_instr_i;
                rs_q       <= id_rs_i;
                rd_q       <= id_rd_addr_i;
                rd_clean_q <= !sb[id_rd_addr_i];
                rd_pair_q  <= rd_pair;
            end
        end
    end

    assign x_valid_o      = (state_q == ISSUE);
    assign x_instr_data_o = instr_q;
    assign x_rs_o         = rs_q;
    assign x_rs_valid_o   = x_valid_o ? RS_VALID : '0;
    assign x_rd_clean_o   = rd_clean_q;

    assign sb_set = id_offload_done_o && x_writeback_i;

    // Core WB owns the write port; a result with nothing outstanding is drained but dropped.
    assign x_rready_o = !core_wb_we_i && !rst_i;
    assign res_hs     = x_rvalid_i && x_rready_o;
    assign res_fire   = res_hs && !empty;

`ifdef CV32E40P_X_DUALWB_EN
    logic beat_q;

    assign dual_first = x_dualwb_i && !beat_q;
    assign wb_addr    = beat_q ? (x_rd_i + 5'd1) : x_rd_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= 1'b0;
        end else if (res_fire) begin
            beat_q <= dual_first;
        end
    end
`else
    logic unused_dualwb;

    assign unused_dualwb = x_dualwb_i;
    assign dual_first    = 1'b0;
    assign wb_addr       = x_rd_i;
`endif

    assign rf_x_we_o    = res_fire && !x_error_i && (wb_addr != '0);
    assign rf_x_waddr_o = res_fire ? wb_addr : '0;
    assign rf_x_wdata_o = res_fire ? x_data_i : '0;
    assign x_err_o      = res_fire && x_error_i;

    cv32e40p_x_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (sb_set),
        .set_addr_i (rd_q),
        .set_pair_i (rd_pair_q),
        .clr_i      (res_fire),
        .clr_addr_i (wb_addr),
        .inc_i      (sb_set),
        .dec_i      (res_fire && !dual_first),
        .sb_o       (sb),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign outstanding_o = count;

`ifndef SYNTHESIS
    result_without_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) !(res_hs && empty)
    );
`endif

endmodule
